// File: rtl/nibble_serial_add_seq_if.sv
// Request/result handshake and 4-bit adder hookup of the nibble-serial add sequencer.
interface nibble_serial_add_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic [W-1:0] result;
    logic         cout_out;
    logic         busy;
    logic         done;

    modport master (
        output start, op_a, op_b, cin_in, add_sum, add_cout,
        input  add_a, add_b, add_cin, result, cout_out, busy, done
    );

    modport slave (
        input  start, op_a, op_b, cin_in, add_sum, add_cout,
        output add_a, add_b, add_cin, result, cout_out, busy, done
    );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Adds two 4*NIBBLES-bit operands by feeding an external 4-bit adder one nibble per clock,
// chaining the carry and assembling the result, with a start/busy/done handshake.
module nibble_serial_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_add_seq_if.slave bus
);
    localparam int unsigned   W        = 4 * NIBBLES;
    localparam int unsigned   IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a_sr;
    logic [W-1:0]  r_b_sr;
    logic [W-1:0]  r_result;
    logic          r_carry;
    logic          r_cout;
    logic          r_busy;
    logic          r_done;
    logic [IW-1:0] r_idx;

    logic          w_last;
    logic [IW+1:0] w_lsb;
    logic [W-1:0]  w_nib_mask;
    logic [W-1:0]  w_nib_val;

    assign w_last     = (r_idx == LAST_IDX);
    assign w_lsb      = {r_idx, 2'b00};
    assign w_nib_mask = W'(4'hF) << w_lsb;
    assign w_nib_val  = W'(bus.add_sum) << w_lsb;

    // Sequencer: the shift registers empty to zero on the last nibble and the carry is
    // cleared there, so the adder inputs are already zero in DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_a_sr   <= bus.op_a;
                        r_b_sr   <= bus.op_b;
                        r_carry  <= bus.cin_in;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result <= (r_result & ~w_nib_mask) | w_nib_val;
                    r_a_sr   <= r_a_sr >> 4;
                    r_b_sr   <= r_b_sr >> 4;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_cout  <= bus.add_cout;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_carry <= bus.add_cout;
                        r_idx   <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.add_a    = r_a_sr[3:0];
    assign bus.add_b    = r_b_sr[3:0];
    assign bus.add_cin  = r_carry;
    assign bus.result   = r_result;
    assign bus.cout_out = r_cout;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq: NIBBLES=4/3/1 instances against a cycle-timeline model
// plus directed vectors with hand-computed results.
module tb_nibble_serial_add_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_add_seq_if #(.NIBBLES(4)) if4 ();
    nibble_serial_add_seq_if #(.NIBBLES(3)) if3 ();
    nibble_serial_add_seq_if #(.NIBBLES(1)) if1 ();

    nibble_serial_add_seq #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    nibble_serial_add_seq #(.NIBBLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    nibble_serial_add_seq #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Combinational 4-bit adders the sequencers drive.
    assign {if4.add_cout, if4.add_sum} = 5'(if4.add_a) + 5'(if4.add_b) + 5'(if4.add_cin);
    assign {if3.add_cout, if3.add_sum} = 5'(if3.add_a) + 5'(if3.add_b) + 5'(if3.add_cin);
    assign {if1.add_cout, if1.add_sum} = 5'(if1.add_a) + 5'(if1.add_b) + 5'(if1.add_cin);

    logic [2:0]  t_start;
    logic [2:0]  t_cin;
    logic [15:0] t_a [3];
    logic [15:0] t_b [3];

    assign if4.start = t_start[0]; assign if4.op_a = t_a[0];       assign if4.op_b = t_b[0];       assign if4.cin_in = t_cin[0];
    assign if3.start = t_start[1]; assign if3.op_a = t_a[1][11:0]; assign if3.op_b = t_b[1][11:0]; assign if3.cin_in = t_cin[1];
    assign if1.start = t_start[2]; assign if1.op_a = t_a[2][3:0];  assign if1.op_b = t_b[2][3:0];  assign if1.cin_in = t_cin[2];

    logic [2:0]  w_busy, w_done, w_cin_o;
    logic [3:0]  w_add_a [3];
    logic [3:0]  w_add_b [3];
    logic [16:0] w_obs [3];
    logic [15:0] w_in_a [3];
    logic [15:0] w_in_b [3];

    assign w_busy  = {if1.busy, if3.busy, if4.busy};
    assign w_done  = {if1.done, if3.done, if4.done};
    assign w_cin_o = {if1.add_cin, if3.add_cin, if4.add_cin};
    assign w_add_a[0] = if4.add_a; assign w_add_a[1] = if3.add_a; assign w_add_a[2] = if1.add_a;
    assign w_add_b[0] = if4.add_b; assign w_add_b[1] = if3.add_b; assign w_add_b[2] = if1.add_b;
    assign w_obs[0] = {if4.cout_out, if4.result};
    assign w_obs[1] = {4'b0, if3.cout_out, if3.result};
    assign w_obs[2] = {12'b0, if1.cout_out, if1.result};
    assign w_in_a[0] = if4.op_a; assign w_in_a[1] = {4'b0, if3.op_a}; assign w_in_a[2] = {12'b0, if1.op_a};
    assign w_in_b[0] = if4.op_b; assign w_in_b[1] = {4'b0, if3.op_b}; assign w_in_b[2] = {12'b0, if1.op_b};

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    function automatic int nib(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
    endfunction

    task automatic chk(input string name, input int k, input logic [16:0] act, input logic [16:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d cycle=%0d: got 0x%0h want 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    // Model: m_t = cycles since the accepting edge (-1 idle, 0..N-1 busy, N done cycle).
    int          m_t   [3];
    logic [15:0] m_a   [3];
    logic [15:0] m_b   [3];
    logic        m_c   [3];
    logic [16:0] m_sum [3];
    logic [16:0] m_res [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_t[k]   <= -1;
                m_res[k] <= '0;
            end else if (m_t[k] < 0) begin
                if (t_start[k]) begin
                    m_t[k]   <= 0;
                    m_a[k]   <= w_in_a[k];
                    m_b[k]   <= w_in_b[k];
                    m_c[k]   <= t_cin[k];
                    m_sum[k] <= 17'(w_in_a[k]) + 17'(w_in_b[k]) + 17'(t_cin[k]);
                    m_res[k] <= '0;
                end
            end else if (m_t[k] == nib(k)) begin
                m_t[k] <= -1;
            end else begin
                m_t[k] <= m_t[k] + 1;
                if (m_t[k] + 1 == nib(k)) m_res[k] <= m_sum[k];
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    initial begin
        logic        eb, ed;
        int          sh;
        logic [16:0] mask, ecin;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                eb = (m_t[k] >= 0) && (m_t[k] < nib(k));
                ed = (m_t[k] == nib(k));
                chk("busy", k, 17'(w_busy[k]), 17'(eb));
                chk("done", k, 17'(w_done[k]), 17'(ed));
                chk("busy_done_excl", k, 17'(w_busy[k] & w_done[k]), 17'd0);
                if (eb) begin
                    sh   = 4 * m_t[k];
                    mask = (17'd1 << sh) - 17'd1;
                    ecin = (((17'(m_a[k]) & mask) + (17'(m_b[k]) & mask) + 17'(m_c[k])) >> sh) & 17'd1;
                    chk("add_a", k, 17'(w_add_a[k]), 17'(4'(m_a[k] >> sh)));
                    chk("add_b", k, 17'(w_add_b[k]), 17'(4'(m_b[k] >> sh)));
                    chk("add_cin", k, 17'(w_cin_o[k]), ecin);
                end else begin
                    chk("add_a_idle", k, 17'(w_add_a[k]), 17'd0);
                    chk("add_b_idle", k, 17'(w_add_b[k]), 17'd0);
                    chk("add_cin_idle", k, 17'(w_cin_o[k]), 17'd0);
                end
                if (!(m_t[k] >= 1 && m_t[k] < nib(k)))
                    chk("result", k, w_obs[k], m_res[k]);
            end
        end
    end

    logic [15:0] seq_a;
    logic [3:0]  seq_c;
    int          nbusy;

    task automatic txn(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [16:0] obs, output int lat);
        @(negedge clk);
        t_a[k] = a; t_b[k] = b; t_cin[k] = c; t_start[k] = 1'b1;
        @(negedge clk);
        t_start[k] = 1'b0;
        lat = 0; nbusy = 0; seq_a = '0; seq_c = '0;
        while (!w_done[k] && lat < 100) begin
            if (w_busy[k]) begin
                nbusy++;
                seq_a = {seq_a[11:0], w_add_a[k]};
                seq_c = {seq_c[2:0], w_cin_o[k]};
            end
            @(negedge clk);
            lat++;
        end
        chk("done_seen", k, 17'(w_done[k]), 17'd1);
        obs = w_obs[k];
    endtask

    task automatic wait_done(input int k, output int at);
        int lim = 0;
        while (!w_done[k] && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        chk("done_wait", k, 17'(w_done[k]), 17'd1);
        at = cyc;
    endtask

    initial begin
        logic [16:0] obs;
        logic [15:0] ra, rb, rm;
        logic        rc;
        int          lat, t1, t2, ndone;

        rst = 1'b1; t_start = '0; t_cin = '0;
        for (int k = 0; k < 3; k++) begin t_a[k] = '0; t_b[k] = '0; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", k, 17'(w_busy[k]), 17'd0);
            chk("reset_done", k, 17'(w_done[k]), 17'd0);
            chk("reset_result", k, w_obs[k], 17'd0);
        end
        rst = 1'b0;

        txn(0, 16'h1234, 16'h4321, 1'b0, obs, lat);
        chk("t1_result", 0, obs, 17'h05555);
        chk("t1_latency", 0, 17'(lat), 17'd4);
        chk("t1_busy_cycles", 0, 17'(nbusy), 17'd4);
        chk("t1_add_a_seq", 0, 17'(seq_a), 17'h04321);

        txn(0, 16'hFFFF, 16'h0001, 1'b0, obs, lat);
        chk("t2_result", 0, obs, 17'h10000);
        chk("t2_add_cin_seq", 0, 17'(seq_c), 17'b0111);

        // Start held high across RUN/DONE, operands changed right after acceptance.
        @(negedge clk);
        t_a[0] = 16'hFFFF; t_b[0] = 16'hFFFF; t_cin[0] = 1'b1; t_start[0] = 1'b1;
        @(negedge clk);
        t_a[0] = 16'h0001; t_b[0] = 16'h0001; t_cin[0] = 1'b0;
        wait_done(0, t1);
        chk("t3_first_result", 0, w_obs[0], 17'h1FFFF);
        @(negedge clk);
        wait_done(0, t2);
        chk("t3_second_result", 0, w_obs[0], 17'h00002);
        chk("t3_done_spacing", 0, 17'(t2 - t1), 17'd6);
        t_start[0] = 1'b0;

        // Reset after two RUN edges aborts without a done pulse.
        @(negedge clk);
        t_a[0] = 16'hABCD; t_b[0] = 16'h1111; t_cin[0] = 1'b0; t_start[0] = 1'b1;
        @(negedge clk);
        t_start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_busy_after_rst", 0, 17'(w_busy[0]), 17'd0);
        chk("t4_result_after_rst", 0, w_obs[0], 17'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_done[0]) ndone++;
        end
        chk("t4_no_done", 0, 17'(ndone), 17'd0);
        txn(0, 16'h0F0F, 16'h00F1, 1'b0, obs, lat);
        chk("t4_result", 0, obs, 17'h01000);

        txn(1, 16'h0FFF, 16'h0001, 1'b0, obs, lat);
        chk("n3_result", 1, obs, 17'h01000);
        chk("n3_latency", 1, 17'(lat), 17'd3);

        txn(2, 16'h0009, 16'h0008, 1'b0, obs, lat);
        chk("n1_result_a", 2, obs, 17'h00011);
        chk("n1_latency", 2, 17'(lat), 17'd1);
        txn(2, 16'h0007, 16'h0008, 1'b1, obs, lat);
        chk("n1_result_b", 2, obs, 17'h00010);

        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 2; k++) begin
                rm = (k == 0) ? 16'hFFFF : 16'h0FFF;
                ra = 16'($urandom) & rm;
                rb = 16'($urandom) & rm;
                rc = 1'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                txn(k, ra, rb, rc, obs, lat);
                chk("rand_sum", k, obs, 17'(ra) + 17'(rb) + 17'(rc));
                chk("rand_latency", k, 17'(lat), 17'(nib(k)));
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
